// File: rtl/jzjpcc_muldiv_sequencer.sv
// jzjpcc_muldiv_sequencer: iterative RV32M multiply/divide unit that stalls the front pipeline while it runs
module jzjpcc_muldiv_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        resultValid,
    output logic [31:0] result
);
    typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} State;
    State state;
    logic [2:0]  op;
    logic [5:0]  count;
    logic [31:0] hi, lo, opnd;
    logic        negRes, negRem;
    logic        isSigned1, isSigned2, sign1, sign2, ge;
    logic [31:0] mag1, mag2, fixed;
    logic [32:0] sh, sum;
    logic [63:0] prod;
    always_comb begin
        isSigned1   = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) | (funct3 == 3'b110);
        isSigned2   = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
        sign1       = isSigned1 & rs1[31];
        sign2       = isSigned2 & rs2[31];
        mag1        = sign1 ? -rs1 : rs1;
        mag2        = sign2 ? -rs2 : rs2;
        sh          = {hi, lo[31]};
        ge          = sh >= {1'b0, opnd};
        sum         = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : 33'd0);
        prod        = negRes ? -{hi, lo} : {hi, lo};
        fixed       = ~op[2] ? ((op[1:0] == 2'b00) ? prod[31:0] : prod[63:32])
                    : ~op[1] ? (negRes ? -lo : lo)
                    : (negRem ? -hi : hi);
        stall       = (state == IDLE & start & ~flush) | (state == ITER) | (state == FIXUP);
        busy        = state != IDLE;
        resultValid = (state == DONE) & ~flush;
    end
    // hi holds product high word / remainder, lo holds multiplier / quotient, opnd the other magnitude
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op     <= 3'd0;
            count  <= 6'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            opnd   <= 32'd0;
            negRes <= 1'b0;
            negRem <= 1'b0;
            result <= 32'd0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op     <= funct3;
                    count  <= 6'd0;
                    negRes <= sign1 ^ sign2;
                    negRem <= sign1;
                    hi     <= 32'd0;
                    lo     <= funct3[2] ? mag1 : mag2;
                    opnd   <= funct3[2] ? mag2 : mag1;
                    if (funct3[2] && rs2 == 32'd0) begin
                        state  <= DONE;
                        result <= funct3[1] ? rs1 : 32'hFFFF_FFFF;
                    end else begin
                        state <= ITER;
                    end
                end
                ITER: begin
                    count <= count + 6'd1;
                    if (op[2]) begin
                        hi <= ge ? sh[31:0] - opnd : sh[31:0];
                        lo <= {lo[30:0], ge};
                    end else begin
                        hi <= sum[32:1];
                        lo <= {sum[0], lo[31:1]};
                    end
                    if (count == 6'd31) state <= FIXUP;
                end
                FIXUP: begin
                    result <= fixed;
                    state  <= DONE;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jzjpcc_muldiv_sequencer.sv
// tb_jzjpcc_muldiv_sequencer: directed and random RV32M ops checked against a 64-bit arithmetic model
module tb_jzjpcc_muldiv_sequencer;
    logic        clock = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1 = 32'd0, rs2 = 32'd0;
    logic        stall, busy, resultValid;
    logic [31:0] result;
    int checks = 0, errors = 0;

    jzjpcc_muldiv_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .flush(flush), .stall(stall), .busy(busy), .resultValid(resultValid), .result(result)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            3'd0: p = sa * sb;
            3'd1: begin p = sa * sb; p = p >>> 32; end
            3'd2: begin p = sa * ub; p = p >>> 32; end
            3'd3: begin p = ua * ub; p = p >> 32; end
            3'd4: p = (b == 0) ? -64'sd1 : sa / sb;
            3'd5: p = (b == 0) ? -64'sd1 : ua / ub;
            3'd6: p = (b == 0) ? ua : sa % sb;
            default: p = (b == 0) ? ua : ua % ub;
        endcase
        return p[31:0];
    endfunction

    task automatic runOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int lat, stalls, expLat;
        logic [31:0] exp;
        exp = model(f, a, b);
        expLat = (f[2] && b == 0) ? 1 : 34;
        lat = -1;
        stalls = 0;
        @(negedge clock);
        start = 1'b1; funct3 = f; rs1 = a; rs2 = b;
        for (int c = 0; c < 45 && lat < 0; c++) begin
            #1;
            stalls += int'(stall);
            if (resultValid) begin
                lat = c;
                check($sformatf("result f%0d %h %h", f, a, b), result, exp);
            end
            @(negedge clock);
            start = 1'b0;
        end
        check($sformatf("latency f%0d", f), lat, expLat);
        check($sformatf("stallCycles f%0d", f), stalls, expLat);
    endtask

    logic [2:0]  dirF [13] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6, 3'd6};
    logic [31:0] dirA [13] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                               32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd5};
    logic [31:0] dirB [13] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                               32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] held;
        logic sawValid;
        #1;
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset valid", {31'd0, resultValid}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        check("spot MUL", model(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
        for (int i = 0; i < 13; i++) runOp(dirF[i], dirA[i], dirB[i]);

        // flush a DIVU mid-iteration, then confirm the unit recovers
        held = result;
        sawValid = 1'b0;
        @(negedge clock);
        start = 1'b1; funct3 = 3'd5; rs1 = 32'd9; rs2 = 32'd3;
        for (int c = 0; c < 40; c++) begin
            flush = (c == 10);
            #1;
            sawValid |= resultValid;
            if (c == 11) begin
                check("flush stall", {31'd0, stall}, 32'd0);
                check("flush busy", {31'd0, busy}, 32'd0);
            end
            @(negedge clock);
            start = 1'b0;
        end
        flush = 1'b0;
        check("flush noValid", {31'd0, sawValid}, 32'd0);
        check("flush result held", result, held);
        runOp(3'd0, 32'd3, 32'd4);

        // async reset in the middle of a MUL
        @(negedge clock);
        start = 1'b1; funct3 = 3'd0; rs1 = 32'd123; rs2 = 32'd456;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            start = 1'b0;
        end
        #1;
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("midreset stall", {31'd0, stall}, 32'd0);
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset valid", {31'd0, resultValid}, 32'd0);
        check("midreset result", result, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // start with flush in IDLE is ignored
        @(negedge clock);
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; rs1 = 32'd2; rs2 = 32'd2;
        #1;
        check("startFlush stall", {31'd0, stall}, 32'd0);
        @(negedge clock);
        start = 1'b0; flush = 1'b0;
        #1;
        check("startFlush busy", {31'd0, busy}, 32'd0);
        check("startFlush result", result, 32'd0);

        for (int i = 0; i < 200; i++) runOp(3'($urandom_range(0, 7)), pick(), pick());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/jzjpcc_muldiv_sequencer.md
# jzjpcc_muldiv_sequencer

Iterative RV32M multiply/divide controller attached to the execute stage. It accepts one M-extension operation from the execute stage and holds the front of the pipeline with `stall` while it runs a 32-iteration shift-add multiply or restoring divide. It then presents the 32-bit result for capture into the memory-stage `aluResult` path. It sequences its own internal datapath and has no effect on the main ALU.

## Interface
- Parameters: none.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  execute stage holds an M-extension op. Sampled only in IDLE.
- `funct3`  in  3  op select, sampled with `start`:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1`  in  32  dividend / multiplicand, sampled with `start`.
- `rs2`  in  32  divisor / multiplier, sampled with `start`.
- `flush`  in  1  abort the current op (branch/exception squash).
- `stall`  out  1  hold decode/execute pipeline registers.
- `busy`  out  1  sequencer is not in IDLE.
- `resultValid`  out  1  one-cycle pulse; `result` is valid this cycle.
- `result`  out  32  final result. Holds its value until the next completion.

## Operation
- States: IDLE, ITER, FIXUP, DONE.
- IDLE, `start`=1, `flush`=0:
  - Latch `funct3`, both operands and both operand signs.
  - Convert signed operands to magnitudes:
    - MULH: rs1 and rs2 signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - DIV/REM: both signed.
    - MULHU/DIVU/REMU and MUL: no conversion (MUL low word is sign-agnostic).
  - Load a 6-bit iteration counter with 0.
  - Go to ITER.
  - Exception: divide op with `rs2`==0 goes directly to DONE, with result:
    - DIV/DIVU: 0xFFFFFFFF.
    - REM/REMU: rs1 unchanged.
- ITER: one iteration per cycle, counter increments each cycle. After the iteration with counter=31, go to FIXUP.
  - Multiply: 64-bit product register.
    - If the multiplier LSB is 1, add the multiplicand into the upper half.
    - Then shift the 65-bit {carry, product} right by 1.
  - Divide: restoring.
    - Shift {remainder, quotient} left by 1.
    - Trial-subtract the divisor from the remainder.
    - If non-negative, keep the difference and set quotient LSB = 1.
- FIXUP: negate the magnitude result when required, then go to DONE.
  - Product: negate when operand signs differ (for the signed operands of the op).
  - Quotient: negate when signs differ.
  - Remainder: takes the sign of the dividend.
  - Select the output word:
    - MUL: low word of the 64-bit product.
    - MULH/MULHSU/MULHU: high word.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and REM 0. This falls out of the magnitude arithmetic and must not be special-cased incorrectly.
- DONE:
  - `resultValid`=1, `stall`=0. The pipeline advances and captures `result` this edge.
  - Next state is IDLE. `start` is ignored in DONE because it is the same instruction.
- `flush` in any state:
  - Next state is IDLE, with no `resultValid`. `result` keeps its previous value.
  - In IDLE, `flush` overrides `start`.
- Reset: state IDLE, counter 0, `stall`=0, `busy`=0, `resultValid`=0, `result`=0.

## Timing
- `stall` is combinational: (IDLE & `start` & ~`flush`) | ITER | FIXUP.
  - The first stall cycle is the `start` cycle itself.
- Normal op, `start` at cycle N:
  - ITER covers N+1..N+32.
  - FIXUP at N+33.
  - DONE at N+34: `resultValid`=1, `stall`=0.
  - IDLE at N+35.
  - `stall` is high for cycles N..N+33 (34 cycles).
- Divide by zero, `start` at N: DONE at N+1, `stall` high for cycle N only.
- `result` is registered. It updates on the edge entering DONE and is stable while `resultValid` is high.
- `flush` asserted at cycle K (K in N+1..N+33): IDLE at K+1, and `stall` is low from K+1.
- Asynchronous reset mid-operation returns all outputs to their reset values immediately. No partial result is emitted.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD, `start` at N:
  - `stall` high N..N+33.
  - `resultValid` at N+34 with `result`=0xFFFFFFEB.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
- REM of the same operands → 0xFFFFFFFF.
- DIVU 100 / 7 → 14.
- REMU 100 / 7 → 2.
- Each of the above completes at N+34.
- DIV 5 / 0, `start` at N:
  - `resultValid` at N+1, `result`=0xFFFFFFFF, `stall` high only at N.
  - REMU 5 / 0 → 5.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- DIVU 9 / 3, `start` at N:
  - `flush` at N+10 → `stall` low at N+11, no `resultValid` pulse, `result` unchanged.
  - Then a new MUL 3 × 4 started → 12 after 34 cycles.
- Interrupted operations:
  - `reset` pulse at N+20 of a MUL → all outputs 0 immediately, state IDLE.
  - `start` with `flush` in IDLE → no `stall`, sequencer stays in IDLE.
